// File: rtl/mem_write_buffer.sv
// Posted write buffer in front of the 32x16 Memory: queues write-backs, forwards
// same-address reads, gives read misses priority. Optional macro: WB_COALESCE_EN.
module mem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_full,
  input  logic        rd_req,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_busy,
  output logic        empty,
  output logic [4:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        memread,
  output logic        memwrite,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MWRITE = 2'd1, MREAD = 2'd2} state_t;
  state_t state, state_next;

  logic [4:0]    q_addr   [DEPTH];
  logic [15:0]   q_data   [DEPTH];
  logic [PW-1:0] slot_idx [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic [4:0]    rd_addr_lat;
  logic [DEPTH-1:0] live, fwd_match;
  logic          fwd_hit, coal_hit;
  logic [15:0]   fwd_data, hit_data, head_wdata;
  logic [PW-1:0] coal_idx;
  logic          wr_acc, wr_alloc, rd_acc, same_wr, rd_hit, deq;

  function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return (s >= DEPTH) ? PW'(s - DEPTH) : PW'(s);
  endfunction

  // slot_idx[k] is the entry k places behind the head (k=0 oldest)
  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    assign slot_idx[k]  = slot(head, k);
    assign live[k]      = (CW'(k) < count);
    assign fwd_match[k] = live[k] && (q_addr[slot_idx[k]] == rd_addr);
  end

  // newest matching queued entry wins
  always_comb begin
    fwd_data = 16'h0000;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_data = fwd_match[k] ? q_data[slot_idx[k]] : fwd_data;
    end
  end
  assign fwd_hit = |fwd_match;

`ifdef WB_COALESCE_EN
  logic [DEPTH-1:0] coal_match;
  for (genvar k = 0; k < DEPTH; k++) begin : g_coal
    assign coal_match[k] = live[k] && (q_addr[slot_idx[k]] == wr_addr) &&
                           ((k != 0) || (state != MWRITE));
  end

  // pick the newest entry eligible for an in-place overwrite
  always_comb begin
    coal_idx = {PW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      coal_idx = coal_match[k] ? slot_idx[k] : coal_idx;
    end
  end
  assign coal_hit = |coal_match;
`else
  assign coal_hit = 1'b0;
  assign coal_idx = {PW{1'b0}};
`endif

  assign wr_acc   = wr_req && (!wr_full || coal_hit);
  assign wr_alloc = wr_acc && !coal_hit;
  assign rd_acc   = rd_req && !rd_busy;
  assign same_wr  = wr_acc && (wr_addr == rd_addr);
  assign rd_hit   = fwd_hit || same_wr;
  assign hit_data = same_wr ? wr_data : fwd_data;
  assign deq      = (state == MWRITE) && mem_done;
  // a head overwritten on the very edge its drain launches must launch the new data
  assign head_wdata = (wr_acc && coal_hit && (coal_idx == head)) ? wr_data : q_data[head];
  assign empty    = (count == {CW{1'b0}}) && (state != MWRITE);

  // occupancy bookkeeping
  always_comb begin
    count_next = count;
    case ({wr_alloc, deq})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // next-state: a pending read miss beats queued writes
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rd_busy) begin
          state_next = MREAD;
        end else if (count != {CW{1'b0}}) begin
          state_next = MWRITE;
        end else begin
          state_next = IDLE;
        end
      end
      MWRITE:  state_next = mem_done ? IDLE : MWRITE;
      MREAD:   state_next = mem_done ? IDLE : MREAD;
      default: state_next = IDLE;
    endcase
  end

  // FSM, pointers, read response and registered memory-side controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      head        <= {PW{1'b0}};
      tail        <= {PW{1'b0}};
      count       <= {CW{1'b0}};
      wr_full     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_busy     <= 1'b0;
      rd_data     <= 16'h0000;
      rd_addr_lat <= 5'd0;
      mem_addr    <= 5'd0;
      mem_wdata   <= 16'h0000;
      memread     <= 1'b0;
      memwrite    <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      wr_full  <= (count_next == CW'(DEPTH));
      rd_valid <= 1'b0;
      if (wr_alloc) tail <= slot(tail, 1);
      if (deq)      head <= slot(head, 1);

      if (rd_acc && rd_hit) begin
        rd_valid <= 1'b1;
        rd_data  <= hit_data;
      end else if (rd_acc) begin
        rd_busy     <= 1'b1;
        rd_addr_lat <= rd_addr;
      end else if ((state == MREAD) && mem_done) begin
        rd_valid <= 1'b1;
        rd_data  <= mem_rdata;
        rd_busy  <= 1'b0;
      end

      if ((state == IDLE) && (state_next == MREAD)) begin
        memread  <= 1'b1;
        mem_addr <= rd_addr_lat;
      end else if ((state == IDLE) && (state_next == MWRITE)) begin
        memwrite  <= 1'b1;
        mem_addr  <= q_addr[head];
        mem_wdata <= head_wdata;
      end else if ((state != IDLE) && mem_done) begin
        memread  <= 1'b0;
        memwrite <= 1'b0;
      end
    end
  end

  // entry storage; validity is tracked by head/count, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_alloc) begin
      q_addr[tail] <= wr_addr;
      q_data[tail] <= wr_data;
    end else if (wr_acc) begin
      q_data[coal_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboard bench for mem_write_buffer against an 11-cycle Memory model
// whose default contents are 0x1300 + 2*addr.
module tb_mem_write_buffer;
  localparam int LAT = 11;

  logic        clk;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_full;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic [15:0] rd_data;
  logic        rd_valid, rd_busy, empty;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        memread, memwrite, mem_done;

  mem_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_busy(rd_busy), .empty(empty),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .memread(memread), .memwrite(memwrite),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [5:0]  op_log[$];
  int rdv_count = 0;
  int mr_cycles = 0;
  int gap_viol = 0;
  logic [15:0] tb_mem [32];
  int mcnt = 0;

  assign mem_done  = (memread || memwrite) && (mcnt == LAT - 1);
  assign mem_rdata = tb_mem[mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model
  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = 16'h1300 + 16'(i * 2);
    forever begin
      @(posedge clk);
      if (memwrite && mem_done) tb_mem[mem_addr] <= mem_wdata;
      mcnt <= (memread || memwrite) ? mcnt + 1 : 0;
    end
  end

  // Monitor: operation log, idle-gap rule, read scoreboard
  initial begin
    logic pr, pw, pd;
    pr = 1'b0; pw = 1'b0; pd = 1'b0;
    forever begin
      @(negedge clk);
      if (memread && !pr)  op_log.push_back({1'b1, mem_addr});
      if (memwrite && !pw) op_log.push_back({1'b0, mem_addr});
      if ((memread && memwrite) || (pd && (memread || memwrite)) ||
          (memread && pw) || (memwrite && pr)) gap_viol++;
      if (memread) mr_cycles++;
      if (rd_valid) begin
        rdv_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_extra: rd_valid with data %h but no read outstanding", rd_data);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
      pr = memread; pw = memwrite; pd = mem_done;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(empty && !rd_busy && !memread && exp_q.size() == 0) && n < 400) begin
      tick;
      n++;
    end
    chk(name, 32'(n < 400), 32'd1);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [15:0] d, output int waited);
    wr_addr = a; wr_data = d; wr_req = 1'b1; waited = 0;
    while (wr_full && waited < 100) begin
      tick;
      waited++;
    end
    chk("wr_accept_bound", 32'(waited < 100), 32'd1);
    tick;
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [15:0] e);
    rd_addr = a; rd_req = 1'b1;
    exp_q.push_back(e);
    tick;
    rd_req = 1'b0;
  endtask

  function automatic int count_ops(input int from, input logic [5:0] op);
    int c = 0;
    for (int j = from; j < op_log.size(); j++) if (op_log[j] == op) c++;
    return c;
  endfunction

  function automatic logic [5:0] log_at(input int idx);
    return (idx < op_log.size()) ? op_log[idx] : 6'h3F;
  endfunction

  initial begin
    int w, c0, v0, l0, n, exp_w7;
    tick; tick;
    chk("rst_memread", 32'(memread), 32'd0);
    chk("rst_memwrite", 32'(memwrite), 32'd0);
    chk("rst_wr_full", 32'(wr_full), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_busy", 32'(rd_busy), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    tick;

    // forwarded read of a write that is draining
    l0 = op_log.size();
    do_write(5'd5, 16'hBEEF, w);
    tick;
    rd_addr = 5'd5; rd_req = 1'b1; exp_q.push_back(16'hBEEF);
    tick;
    rd_req = 1'b0;
    chk("fwd_valid_next_cycle", 32'(rd_valid), 32'd1);
    chk("fwd_data_next_cycle", 32'(rd_data), 32'hBEEF);
    wait_idle("fwd_idle");
    chk("fwd_no_memread", 32'(count_ops(l0, {1'b1, 5'd5})), 32'd0);
    chk("fwd_mem5", 32'(tb_mem[5]), 32'hBEEF);

    // read miss on an empty buffer
    c0 = mr_cycles; v0 = rdv_count;
    do_read(5'd9, 16'h1312);
    chk("miss_busy", 32'(rd_busy), 32'd1);
    wait_idle("miss_idle");
    chk("miss_memread_cycles", 32'(mr_cycles - c0), 32'd11);
    chk("miss_one_valid", 32'(rdv_count - v0), 32'd1);

    // fill to DEPTH, fifth write blocks until the first drain retires
    l0 = op_log.size();
    for (int i = 1; i <= 4; i++) begin
      do_write(5'(i), 16'hA000 + 16'(i), w);
      chk("fill_no_wait", 32'(w), 32'd0);
    end
    chk("fill_wr_full", 32'(wr_full), 32'd1);
    wr_addr = 5'd6; wr_data = 16'hA006; wr_req = 1'b1; w = 0;
    while (wr_full && w < 100) begin
      tick;
      w++;
    end
    chk("full_blocked", 32'(w > 0 && w < 100), 32'd1);
    chk("full_first_drained", 32'(tb_mem[1]), 32'hA001);
    chk("full_second_pending", 32'(tb_mem[2]), 32'h1304);
    tick;
    wr_req = 1'b0;
    wait_idle("fill_idle");
    for (int j = 0; j < 5; j++) begin
      chk("fill_order", 32'(log_at(l0 + j)), 32'({1'b0, (j < 4) ? 5'(j + 1) : 5'd6}));
      chk("fill_mem", 32'(tb_mem[(j < 4) ? j + 1 : 6]), 32'(16'hA000 + 16'((j < 4) ? j + 1 : 6)));
    end

    // read miss during the first of three drains
    l0 = op_log.size();
    do_write(5'd10, 16'hC00A, w);
    do_write(5'd11, 16'hC00B, w);
    do_write(5'd12, 16'hC00C, w);
    tick; tick;
    do_read(5'd20, 16'h1328);
    chk("prio_busy", 32'(rd_busy), 32'd1);
    chk("prio_during_write", 32'(memwrite), 32'd1);
    wait_idle("prio_idle");
    chk("prio_op_count", 32'(op_log.size() - l0), 32'd4);
    chk("prio_op0", 32'(log_at(l0)), 32'({1'b0, 5'd10}));
    chk("prio_op1", 32'(log_at(l0 + 1)), 32'({1'b1, 5'd20}));
    chk("prio_op2", 32'(log_at(l0 + 2)), 32'({1'b0, 5'd11}));
    chk("prio_op3", 32'(log_at(l0 + 3)), 32'({1'b0, 5'd12}));
    chk("prio_mem12", 32'(tb_mem[12]), 32'hC00C);

    // newest match wins, same-cycle write is newest of all
    do_write(5'd3, 16'h1111, w);
    do_write(5'd3, 16'h2222, w);
    do_read(5'd3, 16'h2222);
    wr_addr = 5'd3; wr_data = 16'h3333; wr_req = 1'b1;
    rd_addr = 5'd3; rd_req = 1'b1; exp_q.push_back(16'h3333);
    tick;
    wr_req = 1'b0; rd_req = 1'b0;
    wait_idle("newest_idle");
    chk("newest_mem3", 32'(tb_mem[3]), 32'h3333);

    // reset in the middle of a drain
    do_write(5'd13, 16'hD00D, w);
    do_write(5'd14, 16'hD00E, w);
    do_write(5'd15, 16'hD00F, w);
    n = 0;
    while (!memwrite && n < 50) begin
      tick;
      n++;
    end
    chk("rst_drain_started", 32'(memwrite), 32'd1);
    tick; tick;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_memwrite", 32'(memwrite), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    chk("rst_mid_wr_full", 32'(wr_full), 32'd0);
    #2 rst = 1'b0;
    l0 = op_log.size();
    repeat (20) tick;
    chk("rst_no_ops", 32'(op_log.size() - l0), 32'd0);
    chk("rst_mem13", 32'(tb_mem[13]), 32'h131A);

    // duplicate-address write while full
    l0 = op_log.size();
    do_write(5'd16, 16'hA010, w);
    do_write(5'd17, 16'hA011, w);
    do_write(5'd7,  16'h1111, w);
    do_write(5'd18, 16'hA012, w);
    chk("dup_full", 32'(wr_full), 32'd1);
`ifdef WB_COALESCE_EN
    wr_addr = 5'd7; wr_data = 16'h2222; wr_req = 1'b1;
    tick;
    wr_req = 1'b0;
    chk("coal_still_full", 32'(wr_full), 32'd1);
    exp_w7 = 1;
`else
    do_write(5'd7, 16'h2222, w);
    chk("nocoal_blocked", 32'(w > 0), 32'd1);
    exp_w7 = 2;
`endif
    wait_idle("dup_idle");
    chk("dup_mem7", 32'(tb_mem[7]), 32'h2222);
    chk("dup_writes_to_7", 32'(count_ops(l0, {1'b0, 5'd7})), 32'(exp_w7));
    chk("dup_mem18", 32'(tb_mem[18]), 32'hA012);

    chk("idle_gap_rule", 32'(gap_viol), 32'd0);
    chk("rd_valid_pulses", 32'(rdv_count), 32'd5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
